// File: rtl/multi_input_logic_pipe_pkg.sv
// Shared constants for the multi-input logic pipeline: op encodings and the
// legal parameter ranges checked at elaboration.
package multi_input_logic_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_OR   = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;

  // Codes 6 and 7 are held back for future ops.
  function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
    return op > OP_XNOR;
  endfunction

endpackage

// File: rtl/logic_reduce.sv
// Purely combinational bitwise reduction of NUM_IN operands under a selected
// logic op; reserved op codes yield an all-zero result.
module logic_reduce
  import multi_input_logic_pipe_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 1
) (
  input  logic [NUM_IN*WIDTH-1:0] operands,
  input  logic [OP_W-1:0]         op,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] xor_r;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    or_r  = '0;
    and_r = '1;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      or_r  = or_r  | operands[k*WIDTH +: WIDTH];
      and_r = and_r & operands[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_OR:   result = or_r;
      OP_AND:  result = and_r;
      OP_XOR:  result = xor_r;
      OP_NOR:  result = ~or_r;
      OP_NAND: result = ~and_r;
      OP_XNOR: result = ~xor_r;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multi_input_logic_pipe.sv
// Two-stage valid/ready pipeline: stage 1 registers operands and op, stage 2
// registers the reduced result. Full throughput, backpressure-safe.
module multi_input_logic_pipe
  import multi_input_logic_pipe_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    op_err
);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("multi_input_logic_pipe: NUM_IN out of range 2..16");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("multi_input_logic_pipe: WIDTH out of range 1..32");
  end

  logic                    s1_valid_q, s1_valid_d;
  logic [NUM_IN*WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [OP_W-1:0]         s1_op_q,    s1_op_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]        s2_data_q,  s2_data_d;
  logic                    op_err_q,   op_err_d;

  logic             s1_free;
  logic             s2_free;
  logic             accept;
  logic [WIDTH-1:0] reduce_res;

  // in_ready depends combinationally on out_ready, so a stalled pipe opens
  // up in the same cycle the consumer returns.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_free  = !s1_valid_q || s2_free;
  assign in_ready = s1_free;
  assign accept   = in_valid && s1_free;

  logic_reduce #(
    .NUM_IN (NUM_IN),
    .WIDTH  (WIDTH)
  ) u_reduce (
    .operands (s1_data_q),
    .op       (s1_op_q),
    .result   (reduce_res)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    op_err_d   = op_err_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_op_d    = in_op;
    end else if (s1_free) begin
      s1_valid_d = 1'b0;
    end

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = reduce_res;
      if (s1_valid_q && op_is_reserved(s1_op_q)) begin
        op_err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      op_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      op_err_q   <= op_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign op_err    = op_err_q;

endmodule
